// File: rtl/mul_nibble_seq_if.sv
// Request/response handshake bundle for the nibble-serial multiply sequencer.
// master drives requests and consumes results; slave is the sequencer side.
interface mul_nibble_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_rs1;
    logic [WIDTH-1:0] in_rs2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/mul_nibble_seq.sv
// Iterative RV32M multiply sequencer: one 4x4 nibble product per cycle into a
// 2*WIDTH accumulator, sign fix-up at the end, selected half handed to writeback.
module mul_nibble_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    mul_nibble_seq_if.slave        bus,
    output logic [3:0]             mul_a,
    output logic [3:0]             mul_b,
    input  logic [7:0]             mul_p
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_d;
    logic [1:0]       op, op_d;
    logic [WIDTH-1:0] a_mag, a_mag_d, b_mag, b_mag_d;
    logic             neg, neg_d;
    logic [AW-1:0]    acc, acc_d, acc_fix;
    logic [CW-1:0]    i, i_d, j, j_d;
    logic [CW+2:0]    sh;
    logic             sign_a, sign_b;
    logic             ready_q, valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       mul_a_d, mul_b_d;

    assign bus.in_ready   = ready_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;

    // State register plus registered outputs derived from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= 2'b00;
            a_mag    <= '0;
            b_mag    <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            mul_a    <= 4'h0;
            mul_b    <= 4'h0;
        end else begin
            state    <= state_d;
            op       <= op_d;
            a_mag    <= a_mag_d;
            b_mag    <= b_mag_d;
            neg      <= neg_d;
            acc      <= acc_d;
            i        <= i_d;
            j        <= j_d;
            ready_q  <= (state_d == IDLE);
            valid_q  <= (state_d == DONE);
            result_q <= result_d;
            mul_a    <= mul_a_d;
            mul_b    <= mul_b_d;
        end
    end

    // Next-state, datapath updates and next multiplier operands.
    always_comb begin
        state_d  = state;
        op_d     = op;
        a_mag_d  = a_mag;
        b_mag_d  = b_mag;
        neg_d    = neg;
        acc_d    = acc;
        i_d      = i;
        j_d      = j;
        result_d = result_q;
        sign_a   = 1'b0;
        sign_b   = 1'b0;
        acc_fix  = neg ? (-acc) : acc;
        sh       = {(CW+1)'(i) + (CW+1)'(j), 2'b00};

        if (flush) begin
            state_d  = IDLE;
            i_d      = '0;
            j_d      = '0;
            neg_d    = 1'b0;
            acc_d    = '0;
            result_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // A signed for MUL/MULH/MULHSU, B signed for MUL/MULH only.
                        sign_a  = (bus.in_op != 2'b11) && bus.in_rs1[WIDTH-1];
                        sign_b  = !bus.in_op[1] && bus.in_rs2[WIDTH-1];
                        op_d    = bus.in_op;
                        a_mag_d = sign_a ? (-bus.in_rs1) : bus.in_rs1;
                        b_mag_d = sign_b ? (-bus.in_rs2) : bus.in_rs2;
                        neg_d   = sign_a ^ sign_b;
                        acc_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d = acc + (AW'(mul_p) << sh);
                    if (j == CW'(N - 1)) begin
                        j_d = '0;
                        if (i == CW'(N - 1)) begin
                            i_d     = '0;
                            state_d = FIX;
                        end else begin
                            i_d = i + 1'b1;
                        end
                    end else begin
                        j_d = j + 1'b1;
                    end
                end
                FIX: begin
                    acc_d    = acc_fix;
                    result_d = (op == 2'b00) ? acc_fix[WIDTH-1:0] : acc_fix[AW-1:WIDTH];
                    state_d  = DONE;
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        mul_a_d = (state_d == CALC) ? a_mag_d[{i_d, 2'b00} +: 4] : 4'h0;
        mul_b_d = (state_d == CALC) ? b_mag_d[{j_d, 2'b00} +: 4] : 4'h0;
    end
endmodule

// File: tb/tb_mul_nibble_seq.sv
// Scoreboard bench for mul_nibble_seq: driver pushes expected results at
// acceptance, an independent monitor pops and compares on each handshake.
module tb_mul_nibble_seq;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = 66;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_p;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    int          waits, cnt;

    always #5 clk = ~clk;

    // Reference 4x4 multiplier the sequencer drives.
    assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

    mul_nibble_seq_if #(.WIDTH(WIDTH)) bus ();

    mul_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_p (mul_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request; returns after the acceptance edge plus 2 time units.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input logic [31:0] exp, input bit push,
                         output int n_wait);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        n_wait       = 0;
        while (!bus.in_ready && n_wait < 300) begin
            @(posedge clk);
            #2;
            n_wait++;
        end
        if (!bus.in_ready) check({name, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        if (push) sb.push_back('{name, exp});
        #2;
        bus.in_valid = 1'b0;
        bus.in_op    = ~op;
        bus.in_rs1   = 32'hDEAD_BEEF;
        bus.in_rs2   = 32'h1234_5678;
    endtask

    // Count edges from acceptance until out_valid is seen; ends 1 unit after that edge.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!bus.out_valid && n < 300);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name, input logic [31:0] exp);
        int w, n;
        issue(op, a, b, name, exp, 1'b1, w);
        wait_valid(n);
        check({name, "_latency"}, 32'(n + 1), 32'(LAT));
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares each handshake and checks stability under backpressure.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                if (stalled) begin
                    check("hold_result", bus.out_result, held);
                    check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                end
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'(bus.out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check(e.name, bus.out_result, e.val);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_result;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);

        run_op(2'b00, 32'd3,         32'd5,         "mul_3x5",          32'h0000_000F);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones",       32'hFFFF_FFFE);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones",         32'h0000_0001);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mulh_minneg",      32'h4000_0000);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, "mulh_m1x2",        32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1xmax",    32'hFFFF_FFFF);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones_again", 32'hFFFF_FFFE);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "mul_minneg_xm1",   32'h8000_0000);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "mulh_minneg_xm1",  32'h0000_0000);
        run_op(2'b10, 32'h8000_0000, 32'h0000_0002, "mulhsu_minneg_x2", 32'hFFFF_FFFF);

        // Backpressure in DONE, then back-to-back acceptance after release.
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, "mulhu_2p32", 32'h0000_0001, 1'b1, waits);
        bus.out_ready = 1'b0;
        wait_valid(cnt);
        check("bp_latency", 32'(cnt + 1), 32'(LAT));
        repeat (10) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        issue(2'b00, 32'd2, 32'd3, "mul_2x3_b2b", 32'h0000_0006, 1'b1, waits);
        check("b2b_accept_wait", 32'(waits), 32'd1);
        wait_valid(cnt);
        check("b2b_latency", 32'(cnt + 1), 32'(LAT));
        @(posedge clk);
        #2;

        // Flush sampled on edge 20 of an operation.
        issue(2'b00, 32'd3, 32'd5, "flushed", 32'h0, 1'b0, waits);
        repeat (19) @(posedge clk);
        #2;
        flush = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        repeat (80) @(posedge clk);
        #2;

        // Asynchronous reset during cycle 30 of an operation.
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, "reset_op", 32'h0, 1'b0, waits);
        repeat (29) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_result", bus.out_result, 32'd0);
        check("arst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #2;

        run_op(2'b00, 32'd7, 32'd6, "mul_7x6", 32'h0000_002A);

        cnt = 0;
        while (sb.size() != 0 && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
